// File: rtl/matvec_stream.sv
// matvec_stream: streaming fixed-point matrix-vector multiply, emitting one row result per handshake.
// Optional macro MATVEC_SAT_EN: saturate results when narrowing instead of two's-complement wrap.
module matvec_stream #(
    parameter int MAX_ROWS   = 64,
    parameter int MAX_COLS   = 64,
    parameter int BANDWIDTH  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 12
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [$clog2(MAX_ROWS):0]                   num_rows,
    input  logic [$clog2(MAX_COLS):0]                   num_cols,
    input  logic                                        vector_write_enable,
    input  logic [$clog2(MAX_COLS)-1:0]                 vector_base_addr,
    input  logic signed [BANDWIDTH-1:0][DATA_WIDTH-1:0] vector_in,
    output logic [$clog2(MAX_ROWS*MAX_COLS)-1:0]        matrix_addr,
    output logic                                        matrix_enable,
    input  logic signed [BANDWIDTH-1:0][DATA_WIDTH-1:0] matrix_data,
    input  logic                                        matrix_ready,
    output logic signed [DATA_WIDTH-1:0]                result_out,
    output logic [$clog2(MAX_ROWS)-1:0]                 result_row,
    output logic                                        result_valid,
    input  logic                                        result_ready,
    output logic                                        busy,
    output logic                                        done
);
    localparam int RW = $clog2(MAX_ROWS) + 1;
    localparam int CW = $clog2(MAX_COLS) + 1;
    localparam int VA = $clog2(MAX_COLS);
    localparam int MA = $clog2(MAX_ROWS * MAX_COLS);
    localparam int RR = $clog2(MAX_ROWS);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + $clog2(MAX_COLS);

    typedef enum logic [2:0] {IDLE, VLOAD, FETCH, MAC, EMIT} state_t;

    state_t                state_reg, state_next;
    logic [RW-1:0]         rows_reg, row_reg, row_inc;
    logic [CW-1:0]         cols_reg;
    logic [CW:0]           vcount_reg, col_reg, col_step;
    logic [MA-1:0]         row_base_reg;
    logic signed [AW-1:0]  acc_reg, lane_sum, shifted;
    logic                  done_reg;

    logic [DATA_WIDTH-1:0] vec_mem [MAX_COLS];
    logic [DATA_WIDTH-1:0] vec_lane_reg [BANDWIDTH];
    logic signed [BANDWIDTH-1:0][DATA_WIDTH-1:0] mdata_reg;

    logic [VA:0]           wr_idx [BANDWIDTH];
    logic [CW:0]           rd_idx [BANDWIDTH];
    logic [BANDWIDTH-1:0]  lane_ok;
    logic signed [PW-1:0]  prod [BANDWIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < BANDWIDTH; gi++) begin : g_lane
            assign wr_idx[gi]  = {1'b0, vector_base_addr} + (VA+1)'(gi);
            assign rd_idx[gi]  = col_reg + (CW+1)'(gi);
            assign lane_ok[gi] = rd_idx[gi] < {1'b0, cols_reg};
            assign prod[gi]    = $signed(mdata_reg[gi]) * $signed(vec_lane_reg[gi]);
        end
    endgenerate

    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < BANDWIDTH; j++) begin
            if (lane_ok[j]) begin
                lane_sum = lane_sum + {{(AW-PW){prod[j][PW-1]}}, prod[j]};
            end
        end
    end

    assign col_step = col_reg + (CW+1)'(BANDWIDTH);
    assign row_inc  = row_reg + RW'(1);

    // Vector lanes are read one cycle ahead, while FETCH holds col steady.
    always_ff @(posedge clk) begin
        for (int j = 0; j < BANDWIDTH; j++) begin
            if (state_reg == VLOAD && vector_write_enable && wr_idx[j] < (VA+1)'(MAX_COLS)) begin
                vec_mem[wr_idx[j][VA-1:0]] <= vector_in[j];
            end
            vec_lane_reg[j] <= (rd_idx[j] < (CW+1)'(MAX_COLS)) ? vec_mem[rd_idx[j][VA-1:0]] : '0;
        end
        if (state_reg == FETCH && matrix_ready) begin
            mdata_reg <= matrix_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start && num_rows != '0 && num_cols != '0) state_next = VLOAD;
            VLOAD: if (vcount_reg >= {1'b0, cols_reg}) state_next = FETCH;
            FETCH: if (matrix_ready) state_next = MAC;
            MAC:   state_next = (col_step >= {1'b0, cols_reg}) ? EMIT : FETCH;
            EMIT:  if (result_ready) state_next = (row_inc == rows_reg) ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rows_reg     <= '0;
            cols_reg     <= '0;
            vcount_reg   <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            row_base_reg <= '0;
            acc_reg      <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    rows_reg     <= num_rows;
                    cols_reg     <= num_cols;
                    vcount_reg   <= '0;
                    row_reg      <= '0;
                    col_reg      <= '0;
                    row_base_reg <= '0;
                    acc_reg      <= '0;
                    done_reg     <= (num_rows == '0) || (num_cols == '0);
                end
                VLOAD: if (vector_write_enable && vcount_reg < {1'b0, cols_reg}) begin
                    vcount_reg <= vcount_reg + (CW+1)'(BANDWIDTH);
                end
                MAC: begin
                    acc_reg <= acc_reg + lane_sum;
                    col_reg <= col_step;
                end
                EMIT: if (result_ready) begin
                    acc_reg      <= '0;
                    row_reg      <= row_inc;
                    col_reg      <= '0;
                    row_base_reg <= row_base_reg + MA'(cols_reg);
                    done_reg     <= (row_inc == rows_reg);
                end
                default: ;
            endcase
        end
    end

    assign matrix_enable = (state_reg == FETCH);
    assign matrix_addr   = matrix_enable ? row_base_reg + MA'(col_reg) : '0;
    assign result_valid  = (state_reg == EMIT);
    assign result_row    = row_reg[RR-1:0];
    assign busy          = (state_reg != IDLE);
    assign done          = done_reg;
    assign shifted       = acc_reg >>> FRAC_BITS;

`ifdef MATVEC_SAT_EN
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    always_comb begin
        if (shifted > SAT_HI)      result_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (shifted < SAT_LO) result_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                       result_out = shifted[DATA_WIDTH-1:0];
    end
`else
    assign result_out = DATA_WIDTH'(shifted);
`endif

endmodule

// File: tb/tb_matvec_stream.sv
// Directed self-checking bench for matvec_stream with a behavioural matrix memory responder.
module tb_matvec_stream;
    typedef logic signed [3:0][15:0] beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  num_rows = '0;
    logic [6:0]  num_cols = '0;
    logic        vector_write_enable = 1'b0;
    logic [5:0]  vector_base_addr = '0;
    beat_t       vector_in = '0;
    logic [11:0] matrix_addr;
    logic        matrix_enable;
    beat_t       matrix_data = '0;
    logic        matrix_ready = 1'b0;
    logic signed [15:0] result_out;
    logic [5:0]  result_row;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int mem_mode = 0;
    int mem_lat = 0;
    int lat_cnt = 0;
    int fetch_cnt = 0;
    int overlap_cnt = 0;

    matvec_stream #(
        .MAX_ROWS(64), .MAX_COLS(64), .BANDWIDTH(4), .DATA_WIDTH(16), .FRAC_BITS(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
        .vector_write_enable(vector_write_enable), .vector_base_addr(vector_base_addr),
        .vector_in(vector_in), .matrix_addr(matrix_addr), .matrix_enable(matrix_enable),
        .matrix_data(matrix_data), .matrix_ready(matrix_ready), .result_out(result_out),
        .result_row(result_row), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic signed [15:0] elem(input int a);
        case (mem_mode)
            0: return 16'(a * 1024);
            1: return 16'sh7000;
            2: return -16'sd4096;
            3: return (a == 0 || a == 1 || a == 62 || a == 63) ? 16'sd4096 : 16'sd0;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic beat_t splat(input logic signed [15:0] x);
        return {x, x, x, x};
    endfunction

    // Memory model: answers a fetch after mem_lat wait cycles with elem[addr+j] on lane j.
    always @(negedge clk) begin
        if (matrix_enable) begin
            fetch_cnt++;
            if (result_valid) overlap_cnt++;
            if (lat_cnt >= mem_lat) begin
                matrix_ready = 1'b1;
                for (int j = 0; j < 4; j++) matrix_data[j] = elem(int'(matrix_addr) + j);
                lat_cnt = 0;
            end else begin
                matrix_ready = 1'b0;
                lat_cnt++;
            end
        end else begin
            matrix_ready = 1'b0;
            lat_cnt = 0;
        end
    end

    task automatic do_start(input logic [6:0] rows, input logic [6:0] cols);
        num_rows = rows;
        num_cols = cols;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_beat(input logic [5:0] base, input beat_t v);
        vector_write_enable = 1'b1;
        vector_base_addr = base;
        vector_in = v;
        @(negedge clk);
        vector_write_enable = 1'b0;
    endtask

    task automatic wait_result(output logic signed [15:0] v, output logic [5:0] r, output bit ok);
        ok = 1'b0;
        v = '0;
        r = '0;
        for (int i = 0; i < 300; i++) begin
            if (result_valid) begin
                v = result_out;
                r = result_row;
                ok = 1'b1;
                result_ready = 1'b1;
                @(negedge clk);
                result_ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
        $display("result row=%0d value=%0d seen=%0d", r, v, ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", busy); end
        total++; if (result_valid !== 1'b0 || done !== 1'b0 || matrix_enable !== 1'b0) begin
            bad++; $display("FAIL reset_flags got valid=%0d done=%0d en=%0d want=0/0/0", result_valid, done, matrix_enable);
        end
        total++; if (result_out !== 16'sd0 || result_row !== 6'd0 || matrix_addr !== 12'd0) begin
            bad++; $display("FAIL reset_data got out=%0d row=%0d addr=%0d want=0/0/0", result_out, result_row, matrix_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic signed [15:0] v; logic [5:0] r; bit ok;
        mem_mode = 0; mem_lat = 1; overlap_cnt = 0;
        do_start(7'd2, 7'd4);
        load_beat(6'd0, splat(16'sd4096));
        num_rows = 7'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd6144 || r !== 6'd0) begin bad++; $display("FAIL basic_row0 got=%0d row=%0d want=6144 row=0", v, r); end
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd22528 || r !== 6'd1) begin bad++; $display("FAIL basic_row1 got=%0d row=%0d want=22528 row=1", v, r); end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done got done=%0d busy=%0d want=1/0", done, busy); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0d want=0", done); end
        total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL basic_fetch_during_valid got=%0d want=0", overlap_cnt); end
    endtask

    task automatic test_partial();
        logic signed [15:0] v; logic [5:0] r; bit ok;
        mem_mode = 0; mem_lat = 0;
        do_start(7'd2, 7'd3);
        load_beat(6'd0, splat(16'sd4096));
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd3072 || r !== 6'd0) begin bad++; $display("FAIL partial_row0 got=%0d row=%0d want=3072 row=0", v, r); end
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd12288 || r !== 6'd1) begin bad++; $display("FAIL partial_row1 got=%0d row=%0d want=12288 row=1", v, r); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL partial_done got=%0d want=1", done); end
    endtask

    task automatic test_saturate();
        logic signed [15:0] v; logic [5:0] r; bit ok; logic signed [15:0] exp_v;
`ifdef MATVEC_SAT_EN
        exp_v = 16'sd32767;
`else
        exp_v = 16'sd16384;
`endif
        mem_mode = 1; mem_lat = 0;
        do_start(7'd2, 7'd4);
        load_beat(6'd0, splat(16'sh7000));
        for (int k = 0; k < 2; k++) begin
            wait_result(v, r, ok);
            total++; if (!ok || v !== exp_v || r !== 6'(k)) begin bad++; $display("FAIL narrow_row%0d got=%0d want=%0d", k, v, exp_v); end
        end
    endtask

    task automatic test_floor();
        logic signed [15:0] v; logic [5:0] r; bit ok;
        mem_mode = 2; mem_lat = 0;
        do_start(7'd1, 7'd1);
        load_beat(6'd0, {16'sd0, 16'sd0, 16'sd0, 16'sd1});
        wait_result(v, r, ok);
        total++; if (!ok || v !== -16'sd1 || r !== 6'd0) begin bad++; $display("FAIL floor got=%0d row=%0d want=-1 row=0", v, r); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL floor_done got=%0d want=1", done); end
    endtask

    task automatic test_lane_drop();
        logic signed [15:0] v; logic [5:0] r; bit ok;
        mem_mode = 3; mem_lat = 0;
        do_start(7'd1, 7'd64);
        load_beat(6'd0, {16'sd0, 16'sd0, 16'sd200, 16'sd100});
        for (int b = 1; b < 15; b++) load_beat(6'(b * 4), splat(16'sd0));
        load_beat(6'd62, {16'sd6000, 16'sd5000, 16'sd400, 16'sd300});
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd1000) begin bad++; $display("FAIL lane_drop got=%0d want=1000", v); end
    endtask

    task automatic test_stall();
        logic signed [15:0] v; logic [5:0] r; bit ok; bit seen;
        mem_mode = 0; mem_lat = 0; seen = 1'b0;
        do_start(7'd2, 7'd4);
        load_beat(6'd0, splat(16'sd4096));
        for (int i = 0; i < 100 && !seen; i++) begin
            if (result_valid) seen = 1'b1;
            else @(negedge clk);
        end
        v = result_out; r = result_row;
        total++; if (!seen || v !== 16'sd6144 || r !== 6'd0) begin bad++; $display("FAIL stall_first got=%0d row=%0d want=6144 row=0", v, r); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (result_valid !== 1'b1 || result_out !== v || result_row !== r || matrix_enable !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d got valid=%0d out=%0d row=%0d en=%0d want 1/%0d/%0d/0", c, result_valid, result_out, result_row, matrix_enable, v, r);
            end
        end
        wait_result(v, r, ok);
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd22528 || r !== 6'd1) begin bad++; $display("FAIL stall_row1 got=%0d row=%0d want=22528 row=1", v, r); end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] v; logic [5:0] r; bit ok; bit found;
        mem_mode = 0; mem_lat = 0; found = 1'b0;
        do_start(7'd2, 7'd8);
        load_beat(6'd0, splat(16'sd4096));
        load_beat(6'd4, splat(16'sd4096));
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd28672 || r !== 6'd0) begin bad++; $display("FAIL mid_row0 got=%0d row=%0d want=28672 row=0", v, r); end
        for (int i = 0; i < 100 && !found; i++) begin
            if (matrix_enable && matrix_addr == 12'd12) found = 1'b1;
            else @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL mid_fetch_seen got=0 want=1"); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (matrix_enable !== 1'b0 || matrix_addr !== 12'd0 || busy !== 1'b0 || result_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mid_reset_ctrl got en=%0d addr=%0d busy=%0d valid=%0d done=%0d want all 0", matrix_enable, matrix_addr, busy, result_valid, done);
        end
        total++; if (result_out !== 16'sd0 || result_row !== 6'd0) begin
            bad++; $display("FAIL mid_reset_data got out=%0d row=%0d want=0/0", result_out, result_row);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset_idle got busy=%0d done=%0d want=0/0", busy, done); end
    endtask

    task automatic test_zero_dims();
        int fc;
        fc = fetch_cnt;
        do_start(7'd0, 7'd4);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_rows got done=%0d busy=%0d want=1/0", done, busy); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_rows_pulse got=%0d want=0", done); end
        do_start(7'd3, 7'd0);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_cols got done=%0d busy=%0d want=1/0", done, busy); end
        repeat (3) @(negedge clk);
        total++; if (fetch_cnt !== fc) begin bad++; $display("FAIL zero_no_fetch got=%0d want=%0d", fetch_cnt, fc); end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] v; logic [5:0] r; bit ok;
        mem_mode = 0; mem_lat = 2;
        do_start(7'd1, 7'd4);
        load_beat(6'd0, splat(16'sd4096));
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd6144 || done !== 1'b1) begin bad++; $display("FAIL b2b_a got=%0d done=%0d want=6144 done=1", v, done); end
        do_start(7'd2, 7'd4);
        load_beat(6'd0, {16'sd0, 16'sd0, 16'sd4096, 16'sd0});
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd1024 || r !== 6'd0) begin bad++; $display("FAIL b2b_b0 got=%0d row=%0d want=1024 row=0", v, r); end
        wait_result(v, r, ok);
        total++; if (!ok || v !== 16'sd5120 || r !== 6'd1) begin bad++; $display("FAIL b2b_b1 got=%0d row=%0d want=5120 row=1", v, r); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_partial();
        test_saturate();
        test_floor();
        test_lane_drop();
        test_stall();
        test_reset_mid();
        test_zero_dims();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matvec_stream.md
MATVEC_STREAM -- requirements
Module: matvec_stream

Interface
REQ-001 SHALL have parameters: MAX_ROWS, default 64, max matrix rows; MAX_COLS, default 64, max matrix columns; BANDWIDTH, default 4, elements per fetch/write beat; DATA_WIDTH, default 16, signed element width; FRAC_BITS, default 12, fractional bits (Q4.12).
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high; start  in  1  begin job; num_rows  in  $clog2(MAX_ROWS)+1  active rows; num_cols  in  $clog2(MAX_COLS)+1  active columns.
REQ-003 SHALL have ports: vector_write_enable  in  1  vector beat valid; vector_base_addr  in  $clog2(MAX_COLS)  first element index; vector_in  in  BANDWIDTH x DATA_WIDTH signed  vector beat.
REQ-004 SHALL have ports: matrix_addr  out  $clog2(MAX_ROWS*MAX_COLS)  flat element address; matrix_enable  out  1  fetch request; matrix_data  in  BANDWIDTH x DATA_WIDTH signed  fetched elements; matrix_ready  in  1  matrix_data valid.
REQ-005 SHALL have ports: result_out  out  DATA_WIDTH signed  row result; result_row  out  $clog2(MAX_ROWS)  row index; result_valid  out  1  result present; result_ready  in  1  consumer accepts; busy  out  1  job active; done  out  1  one-cycle job-complete pulse.

Function
REQ-006 SHALL implement states IDLE, VLOAD, FETCH, MAC, EMIT.
REQ-007 IDLE: start=1 SHALL latch num_rows/num_cols, clear vector-written count, go VLOAD; start outside IDLE SHALL be ignored.
REQ-008 start with num_rows=0 or num_cols=0 SHALL skip to done pulse next cycle, no fetch, return IDLE.
REQ-009 VLOAD: each vector_write_enable cycle SHALL write vector_in[j] to vector[vector_base_addr+j]; lanes with index >= MAX_COLS SHALL be dropped; count advances by BANDWIDTH.
REQ-010 VLOAD SHALL go FETCH the cycle after count >= num_cols; row=0, col=0.
REQ-011 FETCH: matrix_enable=1, matrix_addr=row*num_cols+col, held stable until matrix_ready=1; that cycle captures matrix_data, go MAC.
REQ-012 MAC (one cycle): acc += sum over j of matrix_data[j]*vector[col+j] for col+j < num_cols only; lanes past num_cols contribute zero; col += BANDWIDTH; col >= num_cols -> EMIT, else FETCH.
REQ-013 Arithmetic: products 2*DATA_WIDTH signed; acc width 2*DATA_WIDTH+$clog2(MAX_COLS), no overflow; result = acc arithmetic-shifted right FRAC_BITS (floor), then narrowed per REQ-019.
REQ-014 EMIT: result_valid=1 with result_out, result_row stable until result_ready=1; handshake cycle: clear acc, row++, col=0; row==num_rows -> done=1 one cycle, IDLE; else FETCH.
REQ-015 matrix_enable SHALL be 0 outside FETCH; no fetch while result_valid=1.
REQ-016 busy SHALL be 1 in every state except IDLE.

Reset
REQ-017 rst=1 at a clk edge SHALL force IDLE from any state, mid-job included; result_out=0, result_row=0, result_valid=0, matrix_enable=0, matrix_addr=0, busy=0, done=0, acc=0.
REQ-018 Vector storage contents SHALL NOT require reset; no read precedes a write within a job.

Configuration
REQ-019 Macro MATVEC_SAT_EN defined: narrowing SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; undefined: narrowing SHALL keep low DATA_WIDTH bits (two's-complement wrap).

Verification
REQ-020 Matrix model elem[a]=a*1024, 2x4, vector all 4096 -> result 6144 (row 0), 22528 (row 1), then done.
REQ-021 Same model, num_cols=3, num_rows=2, vector all 4096 -> 3072, 12288; lane 3 of first beat excluded.
REQ-022 All elements 0x7000, vector 0x7000, 2x4 -> 32767 per row with MATVEC_SAT_EN; 16384 per row without.
REQ-023 1x1, elem -4096, vector 1 -> result_out -1 (floor).
REQ-024 result_ready low 5 cycles during EMIT -> result_out/result_row stable, result_valid=1, matrix_enable=0 throughout.
REQ-025 rst mid-FETCH -> next cycle all outputs zero, IDLE; num_rows=0 start -> done pulse, no matrix_enable.
